uart_rx_fifo: RTL

//   8N1 UART receiver with a small output FIFO. Sits directly upstream of the

---
 rtl/uart_rx_fifo.sv | 272 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver feeding a small circular FIFO that is drained
// over a valid/ready handshake. Reports framing errors and FIFO overrun.
// Frame format is 8N1 by default; defining UART_RX_PARITY_EN builds an 8E1
// receiver with an extra PARITY state and parity check.
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_IDLE   | waiting for a falling edge on the synchronized line
// S_START  | half-bit wait, then confirm the start bit is still low
// S_DATA   | eight data samples, LSB first, one bit period apart
// S_PARITY | even parity sample (only with UART_RX_PARITY_EN)
// S_STOP   | stop sample; push the byte or flag a framing error
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 10,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic                               i_ena,
    input  logic                               i_rx,
    output logic [7:0]                         o_out_data,
    output logic                               o_out_valid,
    input  logic                               i_out_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    o_fifo_count,
    output logic                               o_frame_err,
    output logic                               o_overrun,
    input  logic                               i_clr_overrun
);

    localparam int L_CW = $clog2(CLKS_PER_BIT);
    localparam int L_PW = $clog2(FIFO_DEPTH);
    localparam int L_NW = $clog2(FIFO_DEPTH + 1);

    localparam logic [L_CW-1:0] L_HALF_LAST = L_CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [L_CW-1:0] L_BIT_LAST  = L_CW'(CLKS_PER_BIT - 1);
    localparam logic [L_NW-1:0] L_FULL      = L_NW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_rx_meta;
    logic              r_rx_s;
    logic              r_rx_d;
    logic              w_fall;

    logic [L_CW-1:0]   r_cnt;
    logic [2:0]        r_bit_idx;
    logic [7:0]        r_shift;

    logic              w_cnt_clr;
    logic              w_shift;
    logic              w_push_req;
    logic              w_ferr;

`ifdef UART_RX_PARITY_EN
    logic              r_par_err;
    logic              w_par_smp;
`endif

    logic [7:0]        r_mem [FIFO_DEPTH];
    logic [L_PW-1:0]   r_wr_ptr;
    logic [L_PW-1:0]   r_rd_ptr;
    logic [L_NW-1:0]   r_count;
    logic              r_frame_err;
    logic              r_overrun;

    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic              w_ovr_set;

    assign w_fall = r_rx_d & ~r_rx_s;

    // Two-flop synchronizer on the serial line plus one delay stage for edge detect
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_d    <= 1'b1;
        end else begin
            r_rx_meta <= i_rx;
            r_rx_s    <= r_rx_meta;
            r_rx_d    <= r_rx_s;
        end
    end

    // Receiver state register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and per-cycle strobes for the bit datapath and FIFO
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        w_shift     = 1'b0;
        w_push_req  = 1'b0;
        w_ferr      = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_smp   = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_fall) begin
                    w_state_nxt = S_START;
                    w_cnt_clr   = 1'b1;
                end
            end
            S_START: begin
                if (r_cnt == L_HALF_LAST) begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_cnt == L_BIT_LAST) begin
                    w_cnt_clr = 1'b1;
                    w_shift   = 1'b1;
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (r_cnt == L_BIT_LAST) begin
                    w_cnt_clr   = 1'b1;
                    w_par_smp   = 1'b1;
                    w_state_nxt = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (r_cnt == L_BIT_LAST) begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = S_IDLE;
`ifdef UART_RX_PARITY_EN
                    if (r_rx_s && !r_par_err) begin
`else
                    if (r_rx_s) begin
`endif
                        w_push_req = 1'b1;
                    end else begin
                        w_ferr = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        // Disabled receiver: abandon any frame without side effects
        if (!i_ena) begin
            w_state_nxt = S_IDLE;
            w_cnt_clr   = 1'b1;
            w_shift     = 1'b0;
            w_push_req  = 1'b0;
            w_ferr      = 1'b0;
`ifdef UART_RX_PARITY_EN
            w_par_smp   = 1'b0;
`endif
        end
    end

    // Bit-period counter, bit index and LSB-first shift register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt     <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
        end else begin
            if (w_cnt_clr || r_state == S_IDLE) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + L_CW'(1);
            end
            if (r_state == S_IDLE) begin
                r_bit_idx <= 3'd0;
            end else if (w_shift) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end
            if (w_shift) begin
                r_shift <= {r_rx_s, r_shift[7:1]};
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // Even parity: the received parity bit must equal the XOR of the data bits
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_par_err <= 1'b0;
        end else if (w_par_smp) begin
            r_par_err <= r_rx_s ^ (^r_shift);
        end
    end
`endif

    assign w_full     = (r_count == L_FULL);
    assign w_pop      = o_out_valid & i_out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_ovr_set  = w_push_req & w_full & ~w_pop;

    // FIFO storage; contents need no reset since out_data is masked when empty
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    // FIFO pointers and occupancy count
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + L_PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + L_PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + L_NW'(1);
                2'b01:   r_count <= r_count - L_NW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Frame error pulse and sticky overrun flag (a new overrun beats the clear)
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_ferr;
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end else if (i_clr_overrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign o_out_valid  = (r_count != '0);
    assign o_out_data   = o_out_valid ? r_mem[r_rd_ptr] : 8'h00;
    assign o_fifo_count = r_count;
    assign o_frame_err  = r_frame_err;
    assign o_overrun    = r_overrun;

endmodule
